// File: rtl/serial_sub.sv
// Bit-serial two's-complement subtractor: diff = a - b - bin, one bit per clock, LSB first.
// Latency: start accepted at edge k, done high in the cycle after edge k+WIDTH (WIDTH+1 cycles).
// Backpressure: none; start is ignored while busy, a start during done chains with no idle cycle.
//
// Ports:
//   clk, rst_n       clock and asynchronous active-low reset
//   start, a, b, bin request and operands, captured when start is accepted (IDLE or DONE)
//   busy, done       busy while shifting; done is a one-cycle result-valid pulse
//   diff, bout, ovf  registered result, unsigned borrow-out, signed overflow; held until next start
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             borrow_q, borrow_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  // Full-subtractor slice on the current LSBs and the registered borrow.
  logic x_bit, y_bit, r_bit, d_bit, borrow_nxt;
  assign x_bit      = sa_q[0];
  assign y_bit      = sb_q[0];
  assign r_bit      = borrow_q;
  assign d_bit      = x_bit ^ y_bit ^ r_bit;
  assign borrow_nxt = (~x_bit & y_bit) | (~(x_bit ^ y_bit) & r_bit);

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          sa_d     = a;
          sb_d     = b;
          borrow_d = bin;
          // Operand signs are kept separately because sa/sb are shifted away.
          a_msb_d  = a[WIDTH-1];
          b_msb_d  = b[WIDTH-1];
          cnt_d    = '0;
          state_d  = SHIFT;
        end else begin
          state_d  = IDLE;
        end
      end
      SHIFT: begin
        sa_d     = {1'b0, sa_q[WIDTH-1:1]};
        sb_d     = {1'b0, sb_q[WIDTH-1:1]};
        diff_d   = {d_bit, diff_q[WIDTH-1:1]};
        borrow_d = borrow_nxt;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          // d_bit is the result sign here; overflow only when operand signs differ
          // and the result sign disagrees with the minuend.
          bout_d  = borrow_nxt;
          ovf_d   = (a_msb_q != b_msb_q) && (d_bit != a_msb_q);
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_sub.sv
// Scoreboard bench for serial_sub: directed 8-bit vectors plus an exhaustive 4-bit sweep.
// Expected results are queued at issue time; per-instance monitors pop on every done pulse.
// Monitors also check the done cycle against the issue cycle to verify latency.
module tb_serial_sub;

  typedef struct {
    logic [7:0] diff;
    logic       bout;
    logic       ovf;
    int         done_cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  logic       start8 = 1'b0, bin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, bout8, ovf8;
  logic [7:0] diff8;

  logic       start4 = 1'b0, bin4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4, bout4, ovf4;
  logic [3:0] diff4;

  exp_t q8[$];
  exp_t q4[$];
  exp_t m8, m4;

  serial_sub #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .ovf(ovf8)
  );

  serial_sub #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .bin(bin4),
    .busy(busy4), .done(done4), .diff(diff4), .bout(bout4), .ovf(ovf4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_event(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitors: sample away from the rising edge.
  always @(negedge clk) begin
    if (done8) begin
      if (q8.size() == 0) fail_event("unexpected_done8");
      else begin
        m8 = q8.pop_front();
        chk("diff8", {24'd0, diff8}, {24'd0, m8.diff});
        chk("bout8", {31'd0, bout8}, {31'd0, m8.bout});
        chk("ovf8", {31'd0, ovf8}, {31'd0, m8.ovf});
        chk("done8_cycle", cyc, m8.done_cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (done4) begin
      if (q4.size() == 0) fail_event("unexpected_done4");
      else begin
        m4 = q4.pop_front();
        chk("diff4", {28'd0, diff4}, {24'd0, m4.diff});
        chk("bout4", {31'd0, bout4}, {31'd0, m4.bout});
        chk("ovf4", {31'd0, ovf4}, {31'd0, m4.ovf});
        chk("done4_cycle", cyc, m4.done_cyc);
      end
    end
  end

  // Called at a falling edge; start is accepted at the next rising edge.
  task automatic issue8(input logic [7:0] ia, input logic [7:0] ib, input logic ibin,
                        input bit push, input logic [7:0] ed, input logic eb, input logic eo);
    exp_t e;
    a8 = ia; b8 = ib; bin8 = ibin; start8 = 1'b1;
    if (push) begin
      e.diff = ed; e.bout = eb; e.ovf = eo; e.done_cyc = cyc + 9;
      q8.push_back(e);
    end
    @(negedge clk);
    start8 = 1'b0;
  endtask

  // Returns at the falling edge where done8 is high; counts busy cycles seen on the way.
  task automatic wait_done8(output int nbusy);
    bit seen;
    seen = 1'b0;
    nbusy = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (done8) seen = 1'b1;
      else begin
        if (busy8) nbusy++;
        @(negedge clk);
      end
    end
    if (!seen) fail_event("done8_timeout");
  endtask

  function automatic exp_t ref4(input int ia, input int ib, input int ibin);
    exp_t e;
    int sa, sb, s;
    e.diff = 8'((ia - ib - ibin) & 15);
    e.bout = (ia < ib + ibin);
    sa = (ia >= 8) ? ia - 16 : ia;
    sb = (ib >= 8) ? ib - 16 : ib;
    s = sa - sb - ibin;
    e.ovf = (s < -8) || (s > 7);
    e.done_cyc = 0;
    return e;
  endfunction

  task automatic issue4(input int ia, input int ib, input int ibin);
    exp_t e;
    a4 = 4'(ia); b4 = 4'(ib); bin4 = ibin[0]; start4 = 1'b1;
    e = ref4(ia, ib, ibin);
    e.done_cyc = cyc + 5;
    q4.push_back(e);
    @(negedge clk);
    start4 = 1'b0;
  endtask

  task automatic wait_done4;
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (done4) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) fail_event("done4_timeout");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, nd;

    // Reset state.
    #1;
    chk("rst_busy8", {31'd0, busy8}, 0);
    chk("rst_done8", {31'd0, done8}, 0);
    chk("rst_diff8", {24'd0, diff8}, 0);
    chk("rst_bout8", {31'd0, bout8}, 0);
    chk("rst_ovf8", {31'd0, ovf8}, 0);
    chk("rst_busy4", {31'd0, busy4}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic: 5 - 3.
    issue8(8'h05, 8'h03, 1'b0, 1'b1, 8'h02, 1'b0, 1'b0);
    chk("t1_busy_after_start", {31'd0, busy8}, 1);
    wait_done8(nb);
    chk("t1_busy_cycles", nb, 8);
    @(negedge clk);
    chk("t1_done_one_cycle", {31'd0, done8}, 0);
    chk("t1_idle_busy", {31'd0, busy8}, 0);
    chk("t1_diff_held", {24'd0, diff8}, 32'h02);

    // Negative results and borrow-in.
    issue8(8'h03, 8'h05, 1'b0, 1'b1, 8'hFE, 1'b1, 1'b0);
    wait_done8(nb);
    @(negedge clk);
    issue8(8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0);
    wait_done8(nb);
    @(negedge clk);

    // Signed overflow in both directions.
    issue8(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b1);
    wait_done8(nb);
    @(negedge clk);
    issue8(8'h7F, 8'hFF, 1'b0, 1'b1, 8'h80, 1'b1, 1'b1);
    wait_done8(nb);

    // Reset mid-operation after four bits; held 0x80/1/1 has shifted to diff=0x08.
    issue8(8'h20, 8'h10, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_busy8", {31'd0, busy8}, 0);
    chk("arst_done8", {31'd0, done8}, 0);
    chk("arst_diff8", {24'd0, diff8}, 0);
    chk("arst_bout8", {31'd0, bout8}, 0);
    chk("arst_ovf8", {31'd0, ovf8}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8 || busy8) nd++;
    end
    chk("arst_no_activity", nd, 0);
    issue8(8'h20, 8'h10, 1'b0, 1'b1, 8'h10, 1'b0, 1'b0);
    wait_done8(nb);
    @(negedge clk);

    // Ignored start while busy, then back-to-back start on the done cycle.
    issue8(8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b0, 1'b0);
    @(negedge clk);
    a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait_done8(nb);
    issue8(8'h09, 8'h09, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    chk("b2b_busy_no_idle", {31'd0, busy8}, 1);
    wait_done8(nb);
    @(negedge clk);

    // Exhaustive 4-bit sweep, each op issued on the previous done cycle.
    for (int ia = 0; ia < 16; ia++)
      for (int ib = 0; ib < 16; ib++)
        for (int ic = 0; ic < 2; ic++) begin
          issue4(ia, ib, ic);
          wait_done4();
        end
    repeat (3) @(negedge clk);

    chk("q8_drained", q8.size(), 0);
    chk("q4_drained", q4.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
